// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one memory port between the I-cache and the D-cache.
// Define CACHE_ARB_RR_EN for round-robin on simultaneous requests; default is D-cache priority.
module cache_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_cache_req,
    input  logic [31:0] inst_cache_addr,
    output logic [31:0] inst_cache_rdata,
    output logic        inst_cache_iok,
    input  logic        data_cache_req,
    input  logic [3:0]  data_cache_wen,
    input  logic [31:0] data_cache_addr,
    input  logic [31:0] data_cache_wdata,
    output logic [31:0] data_cache_rdata,
    output logic        data_cache_dok,
    output logic        mem_req,
    output logic [3:0]  mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_e;

    state_e      state_q, state_d;
    logic        grant_q, grant_d;     // 1 = D-cache owns the current transaction
    logic        pick_data;
    logic        any_req;
    logic [3:0]  wen_q, wen_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] irdata_q, irdata_d;
    logic [31:0] drdata_q, drdata_d;

    assign any_req = inst_cache_req | data_cache_req;

`ifdef CACHE_ARB_RR_EN
    logic last_q, last_d;              // 1 = D-cache was granted last

    always_comb begin
        if (inst_cache_req && data_cache_req) begin
            pick_data = ~last_q;
        end else begin
            pick_data = data_cache_req;
        end
        last_d = last_q;
        if (state_q == IDLE && any_req) begin
            last_d = pick_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= 1'b0;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign pick_data = data_cache_req;
`endif

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        addr_d   = addr_q;
        wen_d    = wen_q;
        wdata_d  = wdata_q;
        irdata_d = irdata_q;
        drdata_d = drdata_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d = pick_data;
                    if (pick_data) begin
                        addr_d  = data_cache_addr;
                        wen_d   = data_cache_wen;
                        wdata_d = data_cache_wdata;
                    end else begin
                        addr_d  = inst_cache_addr;
                        wen_d   = '0;
                        wdata_d = '0;
                    end
                    state_d = ADDR;
                end
            end
            // data_ok arriving alongside addr_ok is dropped; only DATA honours it
            ADDR: begin
                if (mem_addr_ok) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (mem_data_ok) begin
                    if (grant_q) begin
                        drdata_d = mem_rdata;
                    end else begin
                        irdata_d = mem_rdata;
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= 1'b0;
            addr_q   <= '0;
            wen_q    <= '0;
            wdata_q  <= '0;
            irdata_q <= '0;
            drdata_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            addr_q   <= addr_d;
            wen_q    <= wen_d;
            wdata_q  <= wdata_d;
            irdata_q <= irdata_d;
            drdata_q <= drdata_d;
        end
    end

    assign mem_req          = (state_q == ADDR);
    assign mem_wen          = wen_q;
    assign mem_addr         = addr_q;
    assign mem_wdata        = wdata_q;
    assign inst_cache_rdata = irdata_q;
    assign data_cache_rdata = drdata_q;
    assign inst_cache_iok   = (state_q == RESP) && !grant_q;
    assign data_cache_dok   = (state_q == RESP) && grant_q;

endmodule
